// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and lane helpers for the load/store controller.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StWr,
        StResp
    } lsu_state_e;

    function automatic logic [4:0] byte_shift(input logic [1:0] off);
        return {off, 3'b000};
    endfunction

    function automatic logic [4:0] half_shift(input logic [1:0] off);
        return {off[1], 4'b0000};
    endfunction

    function automatic logic [31:0] word_index(input logic [31:0] addr);
        return {2'b00, addr[31:2]};
    endfunction

    // Unsigned stores have no meaning, so funct3 100/101 are only legal for loads.
    function automatic logic req_illegal(input logic write, input logic [2:0] f3,
                                         input logic [1:0] off);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = |off;
            F3_BU:   bad = write;
            F3_HU:   bad = write | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath: load extract with sign/zero extension and sub-word store merge.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [BYTE_W-1:0] byte_lane;
    logic [HALF_W-1:0] half_lane;

    always_comb begin
        byte_lane = word_i[byte_shift(offset_i) +: BYTE_W];
        half_lane = word_i[half_shift(offset_i) +: HALF_W];

        case (funct3_i)
            F3_B:    load_o = {{24{byte_lane[BYTE_W-1]}}, byte_lane};
            F3_BU:   load_o = {24'h000000, byte_lane};
            F3_H:    load_o = {{16{half_lane[HALF_W-1]}}, half_lane};
            F3_HU:   load_o = {16'h0000, half_lane};
            F3_W:    load_o = word_i;
            default: load_o = '0;
        endcase

        merge_o = word_i;
        if (funct3_i == F3_B) begin
            merge_o[byte_shift(offset_i) +: BYTE_W] = wdata_i[BYTE_W-1:0];
        end else if (funct3_i == F3_H) begin
            merge_o[half_shift(offset_i) +: HALF_W] = wdata_i;
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: one request at a time, sub-word stores done as read-modify-write.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    lsu_lane u_lane (
        .word_i   (mem_rdata),
        .offset_i (addr_q[1:0]),
        .funct3_i (funct3_q),
        .wdata_i  (wdata_q[15:0]),
        .load_o   (load_data),
        .merge_o  (merge_data)
    );

    // Outputs are registered: each is computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_we_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d     = req_write;
                    funct3_d    = req_funct3;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    if (req_illegal(req_write, req_funct3, req_addr[1:0])) begin
                        state_d     = StResp;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                    end else if (req_write && req_funct3 == F3_W) begin
                        state_d     = StWr;
                        mem_addr_d  = word_index(req_addr);
                        mem_wdata_d = req_wdata;
                        mem_we_d    = 1'b1;
                    end else begin
                        state_d    = StRd;
                        mem_addr_d = word_index(req_addr);
                    end
                end
            end
            StRd: begin
                state_d    = StCap;
                mem_addr_d = word_index(addr_q);
            end
            StCap: begin
                if (write_q) begin
                    state_d     = StWr;
                    mem_addr_d  = word_index(addr_q);
                    mem_wdata_d = merge_data;
                    mem_we_d    = 1'b1;
                end else begin
                    state_d     = StResp;
                    rsp_rdata_d = load_data;
                    rsp_valid_d = 1'b1;
                end
            end
            StWr: begin
                state_d     = StResp;
                rsp_valid_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign req_ready = (state_q == StIdle) && !RST;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios plus random requests against a word-array reference.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic [31:0] last_rdata;
    logic [31:0] last_wdata;
    logic        last_err;
    int          checks = 0;
    int          errors = 0;

    lsu_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read memory with write-through on the same edge.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_addr[3:0]] <= mem_wdata;
            mem_rdata          <= mem_wdata;
        end else begin
            mem_rdata <= mem[mem_addr[3:0]];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outcome of one request, from the architectural rules.
    function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] d, input logic [31:0] old,
                                  output bit err, output logic [31:0] rd, output int rcyc,
                                  output int wcyc, output logic [31:0] neww);
        int          size;
        int          sh;
        logic [31:0] mask;
        logic [31:0] v;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err  = (f3 == 3'd3) || (f3 >= 3'd6) || (w && f3[2]) || ((a % size) != 0);
        sh   = 8 * int'(a % 4);
        mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
        rd   = '0;
        rcyc = 1;
        wcyc = 0;
        neww = old;
        if (!err) begin
            if (!w) begin
                v = (old >> sh) & mask;
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
                rd   = v;
                rcyc = 3;
            end else begin
                neww = (old & ~(mask << sh)) | ((d & mask) << sh);
                rcyc = (size == 4) ? 2 : 4;
                wcyc = rcyc - 1;
            end
        end
    endfunction

    // Issue one request at a negedge in IDLE and follow it to its response.
    task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input bit hold);
        bit          e_err;
        logic [31:0] e_rd;
        logic [31:0] e_word;
        int          e_rcyc;
        int          e_wcyc;
        int          rcyc;
        int          wcnt;
        int          wcyc;
        int          viol;
        logic [31:0] waddr;
        model(w, f3, a, d, ref_mem[a[5:2]], e_err, e_rd, e_rcyc, e_wcyc, e_word);
        check("ready_in_idle", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        @(posedge CLK);
        @(negedge CLK);
        if (!hold) begin
            req_valid  = 1'b0;
            req_write  = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end
        rcyc = -1;
        wcnt = 0;
        wcyc = -1;
        viol = 0;
        waddr = '0;
        last_wdata = '0;
        last_rdata = '0;
        last_err = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_we) begin
                wcnt++;
                wcyc = c;
                waddr = mem_addr;
                last_wdata = mem_wdata;
            end else if (mem_wdata !== 32'h0) begin
                viol++;
            end
            if (!e_err && c < e_rcyc && mem_addr !== {2'b00, a[31:2]}) viol++;
            if (rsp_valid) begin
                rcyc = c;
                last_rdata = rsp_rdata;
                last_err = rsp_err;
                break;
            end
            @(negedge CLK);
        end
        check("rsp_cycle", rcyc, e_rcyc);
        check("rsp_err", {31'b0, last_err}, {31'b0, e_err});
        check("rsp_rdata", last_rdata, e_rd);
        check("we_count", wcnt, (e_wcyc > 0) ? 1 : 0);
        check("addr_wdata_rules", viol, 0);
        if (e_wcyc > 0) begin
            check("we_cycle", wcyc, e_wcyc);
            check("we_addr", waddr, {2'b00, a[31:2]});
            check("we_data", last_wdata, e_word);
        end
        ref_mem[a[5:2]] = e_word;
        if (!hold) begin
            @(negedge CLK);
            check("rsp_pulse_end", {31'b0, rsp_valid}, 32'd0);
            check("idle_mem_addr", mem_addr, 32'd0);
            check("rdata_holds", rsp_rdata, last_rdata);
        end
    endtask

    initial begin
        int          seen;
        logic        bw;
        logic [31:0] ba;
        logic [31:0] bd;
        RST        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_ready", {31'b0, req_ready}, 32'd0);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("reset_mem_we", {31'b0, mem_we}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 16; i++) run_req(1'b1, F3_W, 32'(i * 4), $urandom, 1'b0);

        run_req(1'b1, F3_W, 32'h8, 32'hDEADBEEF, 1'b0);
        check("sw_plan_data", last_wdata, 32'hDEADBEEF);

        run_req(1'b1, F3_W, 32'h8, 32'h80FF7F01, 1'b0);
        run_req(1'b0, F3_B, 32'hB, 32'h0, 1'b0);
        check("lb_plan", last_rdata, 32'hFFFFFF80);
        run_req(1'b0, F3_BU, 32'hB, 32'h0, 1'b0);
        check("lbu_plan", last_rdata, 32'h00000080);
        run_req(1'b0, F3_H, 32'hA, 32'h0, 1'b0);
        check("lh_plan", last_rdata, 32'hFFFF80FF);
        run_req(1'b0, F3_HU, 32'h8, 32'h0, 1'b0);
        check("lhu_plan", last_rdata, 32'h00007F01);
        run_req(1'b0, F3_W, 32'h8, 32'h0, 1'b0);
        check("lw_plan", last_rdata, 32'h80FF7F01);

        run_req(1'b1, F3_W, 32'h8, 32'h11223344, 1'b0);
        run_req(1'b1, F3_B, 32'h9, 32'hFFFFFFAA, 1'b0);
        check("sb_plan", last_wdata, 32'h1122AA44);
        run_req(1'b1, F3_H, 32'hA, 32'h0000BEEF, 1'b0);
        check("sh_plan", last_wdata, 32'hBEEFAA44);

        run_req(1'b0, F3_H, 32'h3, 32'h0, 1'b0);
        check("err_lh_misaligned", {31'b0, last_err}, 32'd1);
        run_req(1'b1, F3_W, 32'h6, 32'h12345678, 1'b0);
        check("err_sw_misaligned", {31'b0, last_err}, 32'd1);
        run_req(1'b0, 3'b011, 32'h0, 32'h0, 1'b0);
        check("err_funct3_011", {31'b0, last_err}, 32'd1);
        run_req(1'b1, F3_BU, 32'h0, 32'h55, 1'b0);
        check("err_store_unsigned", {31'b0, last_err}, 32'd1);

        // SH aborted by reset while the read word is being captured.
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = F3_H;
        req_addr   = 32'hA;
        req_wdata  = 32'h00001234;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("abort_ready_in_reset", {31'b0, req_ready}, 32'd0);
        RST = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (mem_we || rsp_valid) seen++;
            if (c == 1) check("abort_ready_after", {31'b0, req_ready}, 32'd1);
            @(negedge CLK);
        end
        check("abort_no_activity", seen, 0);
        check("abort_word_kept", mem[2], 32'hBEEFAA44);

        // Requests held back to back, alternating SW/LW.
        for (int i = 0; i < 4; i++) begin
            bw = (i % 2 == 0);
            ba = (i < 2) ? 32'h10 : 32'h14;
            bd = (i < 2) ? 32'hCAFEF00D : 32'h0BADC0DE;
            run_req(bw, F3_W, ba, bw ? bd : $urandom, 1'b1);
            if (!bw) check("b2b_load_data", last_rdata, bd);
            if (i == 3) req_valid = 1'b0;
            @(negedge CLK);
        end

        for (int i = 0; i < 40; i++) begin
            run_req(1'($urandom), 3'($urandom), 32'($urandom_range(63)), $urandom, 1'b0);
        end

        for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
